// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver and the byte/status outputs back out.
// slave is the receiver side, master is the line driver / byte consumer side.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      output rx,
      input  data,
      input  data_valid,
      input  frame_err,
      input  rx_busy
   );

   modport slave (
      input  rx,
      output data,
      output data_valid,
      output frame_err,
      output rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority vote at samples 7/8/9 of each bit,
// one-cycle data_valid / frame_err pulses.
module uart_rx #(
   parameter int DIVISOR    = 326,
   parameter int OVERSAMPLE = 16
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave bus
);

   localparam int             CW          = $clog2(DIVISOR);
   localparam logic [CW-1:0]  BAUD_LAST   = CW'(DIVISOR - 1);
   localparam logic [3:0]     SAMPLE_LAST = 4'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_next;
   logic          rx_meta, rx_s, rx_s_d;
   logic [CW-1:0] baud_counter;
   logic [3:0]    sample_counter;
   logic [2:0]    bit_counter, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic [7:0]    data_q, data_next;
   logic          valid_q, valid_next;
   logic          err_q, err_next;
   logic          s7, s8;
   logic          tick, decide, wrap, majority, falling;

   assign tick     = (state != IDLE) && (baud_counter == BAUD_LAST);
   assign decide   = tick && (sample_counter == 4'd9);
   assign wrap     = tick && (sample_counter == SAMPLE_LAST);
   assign majority = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
   assign falling  = rx_s_d & ~rx_s;

   // Synchroniser and edge-detect flops reset to the idle-high line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   // Counters sit at zero in IDLE, so a detected start edge always begins a fresh bit period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_counter   <= '0;
         sample_counter <= '0;
         s7             <= 1'b1;
         s8             <= 1'b1;
      end else if (state == IDLE) begin
         baud_counter   <= '0;
         sample_counter <= '0;
      end else begin
         baud_counter <= tick ? '0 : baud_counter + 1'b1;
         if (tick) begin
            sample_counter <= sample_counter + 4'd1;
            if (sample_counter == 4'd7) s7 <= rx_s;
            if (sample_counter == 4'd8) s8 <= rx_s;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_counter <= '0;
         shift_reg   <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_next;
         bit_counter <= bit_next;
         shift_reg   <= shift_next;
         data_q      <= data_next;
         valid_q     <= valid_next;
         err_q       <= err_next;
      end
   end

   // STOP leaves at the decision tick rather than the end of the stop bit, so a
   // back-to-back start edge is never missed.
   always_comb begin
      state_next = state;
      bit_next   = bit_counter;
      shift_next = shift_reg;
      data_next  = data_q;
      valid_next = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (falling) state_next = START;
         end
         START: begin
            if (decide && majority) begin
               state_next = IDLE;
            end else if (wrap) begin
               state_next = DATA;
               bit_next   = 3'd0;
            end
         end
         DATA: begin
            if (decide) shift_next = {majority, shift_reg[7:1]};
            if (wrap) begin
               if (bit_counter == 3'd7) state_next = STOP;
               else                     bit_next   = bit_counter + 3'd1;
            end
         end
         STOP: begin
            if (decide) begin
               state_next = IDLE;
               if (majority) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.data       = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.rx_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx (DIVISOR=4, 64 clk per bit) against a
// frame-level model: good stop bit -> byte delivered, low stop bit -> one frame error.
module tb_uart_rx;

   localparam int BIT_CLKS = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_if bus();

   uart_rx #(.DIVISOR(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         testsRun  = 0;
   int         failCount = 0;
   logic [7:0] gotQ[$];
   logic [7:0] expQ[$];
   int         gotErr    = 0;
   int         expErr    = 0;
   logic [7:0] expData   = 8'h00;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Collects every output pulse; a pulse longer than one clk shows up as an extra entry.
   always @(negedge clk) begin
      if (bus.data_valid) gotQ.push_back(bus.data);
      if (bus.frame_err) gotErr++;
      if (bus.data_valid || bus.frame_err)
         checkOutput("pulse_exclusive", {31'b0, bus.data_valid & bus.frame_err}, 32'd0);
   end

   function automatic void modelFrame(input logic [7:0] b, input logic stopBit);
      if (stopBit) begin
         expQ.push_back(b);
         expData = b;
      end else begin
         expErr++;
      end
   endfunction

   task automatic checkFrames(input string tag);
      checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
         checkOutput($sformatf("%s_byte%0d", tag, i), {24'b0, gotQ[i]}, {24'b0, expQ[i]});
      checkOutput({tag, "_err"}, gotErr, expErr);
      checkOutput({tag, "_data"}, {24'b0, bus.data}, {24'b0, expData});
      gotQ.delete();
      expQ.delete();
      gotErr = 0;
      expErr = 0;
   endtask

   // glitchBit is a frame bit index (0 = start); abortAt stops driving after that many clk.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int glitchBit,
                                input int glitchOff, input int abortAt, input bit checkBusy);
      logic [9:0] frame;
      frame = {stopBit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < BIT_CLKS; c++) begin
            if (i * BIT_CLKS + c == abortAt) return;
            @(negedge clk);
            bus.rx = frame[i] ^ ((i == glitchBit) && (c >= glitchOff) && (c < glitchOff + 4));
            if (checkBusy && c == 32)
               checkOutput($sformatf("busy_bit%0d", i), {31'b0, bus.rx_busy}, 32'd1);
         end
      end
   endtask

   task automatic idleLine(input int n);
      bus.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      logic       stopBit;
      int         gBit;
      int         gap;

      bus.rx = 1'b1;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_data",  {24'b0, bus.data}, 32'd0);
      checkOutput("rst_valid", {31'b0, bus.data_valid}, 32'd0);
      checkOutput("rst_err",   {31'b0, bus.frame_err}, 32'd0);
      checkOutput("rst_busy",  {31'b0, bus.rx_busy}, 32'd0);
      rst = 1'b0;
      idleLine(20);

      applyStimulus(8'hA5, 1'b1, -1, 0, -1, 1'b1);
      modelFrame(8'hA5, 1'b1);
      idleLine(20);
      checkFrames("t1_a5");

      // Short low pulse: busy while the start bit is being checked, idle after the vote.
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         bus.rx = (c < 20) ? 1'b0 : 1'b1;
         if (c == 30) checkOutput("t2_busy_start", {31'b0, bus.rx_busy}, 32'd1);
         if (c == 60) checkOutput("t2_busy_after", {31'b0, bus.rx_busy}, 32'd0);
      end
      checkFrames("t2_false_start");

      applyStimulus(8'h3C, 1'b0, -1, 0, -1, 1'b0);
      modelFrame(8'h3C, 1'b0);
      idleLine(64);
      checkFrames("t3_frame_err");

      applyStimulus(8'h00, 1'b1, -1, 0, -1, 1'b0);
      modelFrame(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1, -1, 0, -1, 1'b0);
      modelFrame(8'hFF, 1'b1);
      idleLine(20);
      checkFrames("t4_b2b");

      applyStimulus(8'h55, 1'b1, 4, 34, -1, 1'b0);
      modelFrame(8'h55, 1'b1);
      idleLine(20);
      checkFrames("t5_glitch");

      applyStimulus(8'hC3, 1'b1, -1, 0, 5 * BIT_CLKS + 32, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_data",  {24'b0, bus.data}, 32'd0);
      checkOutput("t6_rst_valid", {31'b0, bus.data_valid}, 32'd0);
      checkOutput("t6_rst_err",   {31'b0, bus.frame_err}, 32'd0);
      checkOutput("t6_rst_busy",  {31'b0, bus.rx_busy}, 32'd0);
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      expData = 8'h00;
      idleLine(100);
      checkFrames("t6_abort");
      applyStimulus(8'h5A, 1'b1, -1, 0, -1, 1'b0);
      modelFrame(8'h5A, 1'b1);
      idleLine(20);
      checkFrames("t6_5a");

      for (int n = 0; n < 24; n++) begin
         b       = 8'($urandom);
         stopBit = ($urandom_range(0, 4) != 0);
         gBit    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
         applyStimulus(b, stopBit, gBit, int'($urandom_range(20, 40)), -1, 1'b0);
         modelFrame(b, stopBit);
         gap = stopBit ? int'($urandom_range(0, 30)) : int'($urandom_range(16, 40));
         idleLine(gap);
         checkFrames($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
